// File: rtl/rate_limiter_pkg.sv
// Shared defaults, bucket level type and sizing helper for the token-bucket
// rate limiter and its round-robin arbiter.
package rate_limiter_pkg;

    localparam int DEF_NUM_CH        = 4;
    localparam int DEF_TOKEN_W       = 16;
    localparam int DEF_MAX_TOKENS    = 100;
    localparam int DEF_REFILL_PERIOD = 1000;
    localparam int DEF_REFILL_AMT    = 1;

    typedef logic [DEF_TOKEN_W-1:0] level_t;

    // Width needed to index n items; never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: grants the first eligible channel at or
// after the priority pointer and proposes the pointer for the next cycle.
module rr_arbiter
    import rate_limiter_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    localparam int PTR_W = idx_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] eligible,
    input  logic [PTR_W-1:0]  ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [PTR_W-1:0]  next_ptr
);

    logic found;
    int   idx;

    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // any branch, otherwise a path that skips the assignment infers a latch.
        grant    = '0;
        next_ptr = ptr;
        found    = 1'b0;
        idx      = 0;
        for (int off = 0; off < NUM_CH; off++) begin
            idx = int'(ptr) + off;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!found && eligible[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                next_ptr   = (idx == NUM_CH - 1) ? '0 : PTR_W'(idx + 1);
            end
        end
    end

endmodule

// File: rtl/token_bucket_limiter.sv
// Per-channel token-bucket trade limiter: periodic saturating refill, one
// round-robin grant per cycle, registered approve/reject flags.
module token_bucket_limiter
    import rate_limiter_pkg::*;
#(
    parameter int NUM_CH        = DEF_NUM_CH,
    parameter int TOKEN_W       = DEF_TOKEN_W,
    parameter int MAX_TOKENS    = DEF_MAX_TOKENS,
    parameter int REFILL_PERIOD = DEF_REFILL_PERIOD,
    parameter int REFILL_AMT    = DEF_REFILL_AMT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         trade_request,
    output logic [NUM_CH-1:0]         trade_approved,
    output logic [NUM_CH-1:0]         trade_rejected,
    output logic [NUM_CH*TOKEN_W-1:0] tokens_avail,
    output logic                      refill_pulse
);

    localparam int PTR_W   = idx_width(NUM_CH);
    localparam int TIMER_W = idx_width(REFILL_PERIOD);

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(REFILL_PERIOD - 1);
    localparam logic [TOKEN_W:0]   MAX_EXT    = (TOKEN_W + 1)'(MAX_TOKENS);
    localparam logic [TOKEN_W:0]   AMT_EXT    = (TOKEN_W + 1)'(REFILL_AMT);

    if (NUM_CH < 1 || REFILL_PERIOD < 1 || REFILL_AMT < 1 || REFILL_AMT > MAX_TOKENS ||
        (TOKEN_W < 31 && MAX_TOKENS >= (1 << TOKEN_W))) begin : g_bad_params
        $error("token_bucket_limiter: illegal parameter combination");
    end

    logic [TIMER_W-1:0] timer;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   next_ptr;
    logic               refill_event;
    logic [NUM_CH-1:0]  eligible;
    logic [NUM_CH-1:0]  grant;
    logic [TOKEN_W-1:0] bucket     [NUM_CH];
    logic [TOKEN_W-1:0] bucket_nxt [NUM_CH];
    logic [TOKEN_W:0]   level_sum  [NUM_CH];

    assign refill_event = (timer == TIMER_LAST);

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            eligible[i] = trade_request[i] && (bucket[i] != '0);
        end
    end

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .eligible (eligible),
        .ptr      (ptr),
        .grant    (grant),
        .next_ptr (next_ptr)
    );

    // Refill and consume are folded into one sum so a grant on a refill cycle
    // never loses the refill; saturation is applied after the decrement.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            level_sum[i]  = {1'b0, bucket[i]}
                          + (refill_event ? AMT_EXT : '0)
                          - {{TOKEN_W{1'b0}}, grant[i]};
            bucket_nxt[i] = (level_sum[i] > MAX_EXT) ? MAX_EXT[TOKEN_W-1:0]
                                                     : level_sum[i][TOKEN_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            timer          <= '0;
            ptr            <= '0;
            trade_approved <= '0;
            trade_rejected <= '0;
            refill_pulse   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                bucket[i] <= TOKEN_W'(MAX_TOKENS);
            end
        end else begin
            timer          <= refill_event ? '0 : timer + TIMER_W'(1);
            ptr            <= next_ptr;
            trade_approved <= grant;
            trade_rejected <= trade_request & ~grant;
            refill_pulse   <= refill_event;
            for (int i = 0; i < NUM_CH; i++) begin
                bucket[i] <= bucket_nxt[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_levels
        assign tokens_avail[g*TOKEN_W +: TOKEN_W] = bucket[g];
    end

endmodule

// File: tb/tb_token_bucket_limiter.sv
// Self-checking bench for token_bucket_limiter: directed scenarios plus random
// requests and resets, all compared against a behavioural bucket model.
module tb_token_bucket_limiter;
    import rate_limiter_pkg::*;

    localparam int NUM_CH        = 4;
    localparam int TOKEN_W       = 16;
    localparam int MAX_TOKENS    = 3;
    localparam int REFILL_PERIOD = 8;
    localparam int REFILL_AMT    = 1;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_CH-1:0]         trade_request;
    logic [NUM_CH-1:0]         trade_approved;
    logic [NUM_CH-1:0]         trade_rejected;
    logic [NUM_CH*TOKEN_W-1:0] tokens_avail;
    logic                      refill_pulse;

    always #5 clk = ~clk;

    token_bucket_limiter #(
        .NUM_CH        (NUM_CH),
        .TOKEN_W       (TOKEN_W),
        .MAX_TOKENS    (MAX_TOKENS),
        .REFILL_PERIOD (REFILL_PERIOD),
        .REFILL_AMT    (REFILL_AMT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .trade_request  (trade_request),
        .trade_approved (trade_approved),
        .trade_rejected (trade_rejected),
        .tokens_avail   (tokens_avail),
        .refill_pulse   (refill_pulse)
    );

    // Reference model state: bucket levels, cycles since last refill, next
    // channel to favour.
    int          m_level [NUM_CH];
    int          m_timer;
    int          m_ptr;
    logic [3:0]  e_app;
    logic [3:0]  e_rej;
    logic        e_pulse;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lvl(input int ch);
        level_t v;
        v = tokens_avail[ch*TOKEN_W +: TOKEN_W];
        return int'(v);
    endfunction

    task automatic model_edge(input logic [3:0] req, input logic r);
        int  g;
        int  c;
        int  nl;
        bit  refill;
        if (r) begin
            for (int i = 0; i < NUM_CH; i++) m_level[i] = MAX_TOKENS;
            m_timer = 0;
            m_ptr   = 0;
            e_app   = '0;
            e_rej   = '0;
            e_pulse = 1'b0;
        end else begin
            refill  = (m_timer == REFILL_PERIOD - 1);
            m_timer = refill ? 0 : m_timer + 1;
            g = -1;
            for (int off = 0; off < NUM_CH; off++) begin
                c = (m_ptr + off) % NUM_CH;
                if (g < 0 && req[c] && m_level[c] > 0) g = c;
            end
            e_app = '0;
            if (g >= 0) begin
                e_app[g] = 1'b1;
                m_ptr    = (g + 1) % NUM_CH;
            end
            e_rej   = req & ~e_app;
            e_pulse = refill;
            for (int i = 0; i < NUM_CH; i++) begin
                nl = m_level[i] + (refill ? REFILL_AMT : 0) - ((i == g) ? 1 : 0);
                m_level[i] = (nl > MAX_TOKENS) ? MAX_TOKENS : nl;
            end
        end
    endtask

    // One clock: drive on the falling edge, update the model, check after the
    // rising edge has settled.
    task automatic step(input logic [3:0] req, input logic r);
        @(negedge clk);
        trade_request = req;
        rst           = r;
        model_edge(req, r);
        @(posedge clk);
        #1;
        check("approved", 32'(trade_approved), 32'(e_app));
        check("rejected", 32'(trade_rejected), 32'(e_rej));
        check("refill_pulse", 32'(refill_pulse), 32'(e_pulse));
        check("overlap", 32'(trade_approved & trade_rejected), 32'd0);
        for (int i = 0; i < NUM_CH; i++) check($sformatf("level%0d", i), 32'(lvl(i)), 32'(m_level[i]));
    endtask

    int app_cnt;
    int rej_cnt;
    int pulse_cnt;

    initial begin
        rst           = 1'b1;
        trade_request = '0;
        step(4'h0, 1'b1);
        step(4'h0, 1'b1);
        check("reset_level0", 32'(lvl(0)), 32'd3);
        check("reset_flags", 32'({trade_approved, trade_rejected, refill_pulse}), 32'd0);

        // Single channel exhausts its bucket before the first refill.
        app_cnt = 0;
        rej_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            step(4'h1, 1'b0);
            app_cnt += int'(trade_approved[0]);
            rej_cnt += int'(trade_rejected[0]);
        end
        check("ch0_approved_cnt", 32'(app_cnt), 32'd3);
        check("ch0_rejected_cnt", 32'(rej_cnt), 32'd2);
        check("ch0_empty", 32'(lvl(0)), 32'd0);

        // All channels contend: grants rotate 0,1,2,3,...
        step(4'h0, 1'b1);
        for (int k = 0; k < 12; k++) begin
            step(4'hF, 1'b0);
            check("rotate_app", 32'(trade_approved), 32'(4'b0001 << (k % 4)));
            check("rotate_rej", 32'(trade_rejected), 32'(~(4'b0001 << (k % 4)) & 4'hF));
        end

        // Drain ch1 then watch refills restore it and saturate.
        step(4'h0, 1'b1);
        for (int k = 0; k < 3; k++) step(4'h2, 1'b0);
        check("ch1_drained", 32'(lvl(1)), 32'd0);
        pulse_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            step(4'h0, 1'b0);
            pulse_cnt += int'(refill_pulse);
        end
        check("refill_pulses", 32'(pulse_cnt), 32'd4);
        check("ch1_saturated", 32'(lvl(1)), 32'd3);

        // Grant coinciding with refill on a full bucket, then an empty one.
        step(4'h0, 1'b1);
        for (int k = 0; k < 7; k++) step(4'h0, 1'b0);
        step(4'h4, 1'b0);
        check("full_refill_grant", 32'({refill_pulse, trade_approved[2]}), 32'b11);
        check("full_refill_level", 32'(lvl(2)), 32'd3);
        for (int k = 0; k < 3; k++) step(4'h4, 1'b0);
        check("ch2_drained", 32'(lvl(2)), 32'd0);
        for (int k = 0; k < 4; k++) step(4'h0, 1'b0);
        step(4'h4, 1'b0);
        check("empty_refill_rej", 32'({refill_pulse, trade_approved[2], trade_rejected[2]}), 32'b101);
        check("empty_refill_level", 32'(lvl(2)), 32'd1);

        // Reset pulsed in the middle of a burst.
        for (int k = 0; k < 5; k++) step(4'hF, 1'b0);
        step(4'hF, 1'b1);
        check("mid_rst_flags", 32'({trade_approved, trade_rejected, refill_pulse}), 32'd0);
        for (int i = 0; i < NUM_CH; i++) check("mid_rst_level", 32'(lvl(i)), 32'd3);
        step(4'hF, 1'b0);
        check("post_rst_first_grant", 32'(trade_approved), 32'h1);
        pulse_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            step(4'h0, 1'b0);
            pulse_cnt += int'(refill_pulse);
        end
        check("timer_restart_quiet", 32'(pulse_cnt), 32'd0);
        step(4'h0, 1'b0);
        check("timer_restart_pulse", 32'(refill_pulse), 32'd1);

        // Random traffic with occasional resets.
        for (int k = 0; k < 400; k++) begin
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 63) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
